// File: rtl/seq_divider_pkg.sv
// Shared types and sizing helpers for the sequential restoring divider.
package seq_divider_pkg;

    // Controller states: capture, prepare, iterate, report.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CALC = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam int DEFAULT_N = 8;

    // The counter must be able to hold the value N itself, hence N+1 codes.
    function automatic int cntWidth(input int n);
        return $clog2(n + 1);
    endfunction

    localparam int DEFAULT_CNT_W = cntWidth(DEFAULT_N);

endpackage

// File: rtl/seq_divider_ctrl.sv
// Control FSM for the divider: sequences capture, iteration and result update.
module seq_divider_ctrl
    import seq_divider_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic start_i,
    input  logic mZero_i,
    input  logic cntLast_i,
    output logic load_o,
    output logic shift_en_o,
    output logic cnt_ld_o,
    output logic cnt_en_o,
    output logic result_ld_o,
    output logic busy_o,
    output logic done_o
);

    state_e state_q;
    state_e state_d;

    // State register; reset drops straight back to IDLE without a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and datapath strobes; start is only looked at in IDLE.
    always_comb begin
        state_d     = state_q;
        load_o      = 1'b0;
        shift_en_o  = 1'b0;
        cnt_ld_o    = 1'b0;
        cnt_en_o    = 1'b0;
        result_ld_o = 1'b0;
        busy_o      = 1'b0;
        done_o      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    load_o  = 1'b1;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                busy_o   = 1'b1;
                cnt_ld_o = 1'b1;
                if (mZero_i) begin
                    result_ld_o = 1'b1;
                    state_d     = DONE;
                end else begin
                    state_d = CALC;
                end
            end
            CALC: begin
                busy_o     = 1'b1;
                shift_en_o = 1'b1;
                cnt_en_o   = 1'b1;
                if (cntLast_i) begin
                    result_ld_o = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                busy_o  = 1'b1;
                done_o  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: rtl/seq_divider.sv
// Sequential unsigned restoring divider: one quotient bit per CALC cycle.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int N = DEFAULT_N
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start_i,
    input  logic [N-1:0] dividend_i,
    input  logic [N-1:0] divisor_i,
    output logic         busy_o,
    output logic         done_o,
    output logic [N-1:0] quotient_o,
    output logic [N-1:0] remainder_o,
    output logic         div_by_zero_o
);

    localparam int CntW = cntWidth(N);

    logic [N:0]      aQ, aD;
    logic [N-1:0]    qQ, qD;
    logic [N-1:0]    mQ, mD;
    logic [CntW-1:0] cntQ, cntD;
    logic [N-1:0]    quotQ, quotD;
    logic [N-1:0]    remQ, remD;
    logic            dbzQ, dbzD;

    logic            load, shiftEn, cntLd, cntEn, resultLd;
    logic            mZero, cntLast;
    logic [2*N:0]    aqShifted;
    logic [N:0]      aShift;
    logic [N-1:0]    qShifted;
    logic [N:0]      diff;
    logic            qBit;
    logic [N:0]      aNext;
    logic [N-1:0]    qNext;

    assign mZero   = (mQ == '0);
    assign cntLast = (cntQ == CntW'(1));

    seq_divider_ctrl u_ctrl (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (start_i),
        .mZero_i     (mZero),
        .cntLast_i   (cntLast),
        .load_o      (load),
        .shift_en_o  (shiftEn),
        .cnt_ld_o    (cntLd),
        .cnt_en_o    (cntEn),
        .result_ld_o (resultLd),
        .busy_o      (busy_o),
        .done_o      (done_o)
    );

    // One restoring step: shift {A,Q}, trial-subtract M, keep the difference if it did not borrow.
    always_comb begin
        aqShifted = {aQ, qQ} << 1;
        aShift    = aqShifted[2*N:N];
        qShifted  = aqShifted[N-1:0];
        diff      = aShift - {1'b0, mQ};
        qBit      = ~diff[N];
        aNext     = diff[N] ? aShift : diff;
        qNext     = qShifted | N'(qBit);
    end

    // Next values for all datapath registers, driven by the controller strobes.
    always_comb begin
        aD   = aQ;
        qD   = qQ;
        mD   = mQ;
        cntD = cntQ;
        quotD = quotQ;
        remD  = remQ;
        dbzD  = dbzQ;
        if (load) begin
            qD = dividend_i;
            mD = divisor_i;
        end
        if (cntLd) begin
            aD   = '0;
            cntD = CntW'(N);
        end
        if (shiftEn) begin
            aD = aNext;
            qD = qNext;
        end
        if (cntEn) begin
            cntD = cntQ - CntW'(1);
        end
        if (resultLd) begin
            if (mZero) begin
                quotD = '1;
                remD  = qQ;
                dbzD  = 1'b1;
            end else begin
                quotD = qNext;
                remD  = aNext[N-1:0];
                dbzD  = 1'b0;
            end
        end
    end

    // Datapath and result registers; results only move on the edge into DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aQ    <= '0;
            qQ    <= '0;
            mQ    <= '0;
            cntQ  <= '0;
            quotQ <= '0;
            remQ  <= '0;
            dbzQ  <= 1'b0;
        end else begin
            aQ    <= aD;
            qQ    <= qD;
            mQ    <= mD;
            cntQ  <= cntD;
            quotQ <= quotD;
            remQ  <= remD;
            dbzQ  <= dbzD;
        end
    end

    assign quotient_o    = quotQ;
    assign remainder_o   = remQ;
    assign div_by_zero_o = dbzQ;

endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 Parameter N, default 8, SHALL set the operand and result width in bits.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst  input  1  SHALL be the reset: asynchronous, active-low.
REQ-004 start  input  1  SHALL request a division; sampled only in IDLE.
REQ-005 dividend  input  N  SHALL be the unsigned dividend, captured on the accepting edge.
REQ-006 divisor  input  N  SHALL be the unsigned divisor, captured on the accepting edge.
REQ-007 busy  output  1  SHALL be high in LOAD, CALC and DONE.
REQ-008 done  output  1  SHALL be a one-cycle pulse marking valid results.
REQ-009 quotient  output  N  SHALL hold the last completed quotient.
REQ-010 remainder  output  N  SHALL hold the last completed remainder.
REQ-011 div_by_zero  output  1  SHALL flag that the last operation had divisor 0.

Function
REQ-012 The FSM SHALL have states IDLE, LOAD, CALC and DONE.
REQ-013 IDLE with start=1 SHALL capture dividend into Q and divisor into M, and go to LOAD; start=0 SHALL stay in IDLE.
REQ-014 LOAD SHALL clear the N+1-bit partial remainder A and load the iteration counter with N.
- If M==0, LOAD SHALL go straight to DONE.
- Otherwise LOAD SHALL go to CALC.
REQ-015 Each CALC cycle SHALL perform one restoring step.
- Shift {A,Q} left by one.
- T = A_shifted - {0,M}, computed at N+1 bits.
- If T[N]==0: A<=T and Q[0]<=1; else A keeps the shifted value and Q[0]<=0.
- Decrement the counter.
REQ-016 CALC SHALL transition to DONE on the edge where the counter decrements from 1 to 0, giving exactly N CALC cycles.
REQ-017 On the edge entering DONE, quotient and remainder SHALL be updated.
- Normal case: quotient<=Q, remainder<=A[N-1:0], div_by_zero<=0.
- Zero divisor: quotient<=all ones, remainder<=dividend, div_by_zero<=1.
REQ-018 DONE SHALL assert done for exactly one cycle and then return to IDLE.
REQ-019 Latency SHALL be fixed.
- Normal operation: done high N+2 cycles after the accepting edge.
- Zero divisor: done high 2 cycles after the accepting edge.
REQ-020 start in LOAD, CALC or DONE SHALL be ignored with no effect on the operation in progress; the next request is accepted in IDLE.
REQ-021 quotient, remainder and div_by_zero SHALL hold their values from the DONE update until the next DONE update, and SHALL NOT change during LOAD or CALC.
REQ-022 Operand inputs SHALL be don't-care except on the accepting edge.
REQ-023 All arithmetic SHALL be unsigned; no result overflow is possible because the quotient is at most 2^N-1.

Reset
REQ-024 rst low SHALL immediately, without waiting for a clock edge, force:
- state IDLE;
- busy=0 and done=0;
- quotient, remainder and div_by_zero to 0;
- A, Q, M and the counter to 0.
REQ-025 Reset asserted mid-operation SHALL abort the operation with no done pulse; the first start after reset release SHALL be accepted normally.

Structure
REQ-026 Package seq_divider_pkg SHALL hold the state encoding type and the iteration-count constant width, $clog2(N+1).
REQ-027 The FSM SHALL be a sub-module seq_divider_ctrl.
- Outputs: load, shift_en, cnt_ld, cnt_en and result_ld.
- The datapath (A/Q/M registers, subtractor, counter) remains in seq_divider.

Verification
REQ-028 N=8, dividend=100, divisor=7, start pulse -> done 10 cycles after the accepting edge, quotient=14, remainder=2, div_by_zero=0, busy high throughout.
REQ-029 dividend=255, divisor=1 -> quotient=255, remainder=0; dividend=3, divisor=10 -> quotient=0, remainder=3.
REQ-030 dividend=5, divisor=0 -> done 2 cycles after the accepting edge, quotient=255, remainder=5, div_by_zero=1; the next division 9/3 -> quotient=3, remainder=0, div_by_zero=0.
REQ-031 Start 200/9, then pulse start with 50/5 during CALC -> single done pulse, quotient=22, remainder=2; outputs held afterwards.
REQ-032 Start 100/7, assert rst low in cycle 4 of CALC -> outputs immediately 0, no done pulse; after release 100/7 -> quotient=14, remainder=2.
REQ-033 Randomized back-to-back operations against a reference model: each done pulse exactly N+2 cycles after its accepting edge; quotient*divisor+remainder==dividend and remainder<divisor.
